// File: rtl/wishbone_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_cmd_master
// Description : Bridges a valid/ready host command/response channel onto a
//               classic single-transfer Wishbone master port. One command is
//               in flight at a time: IDLE -> BUS (cyc/stb held until ack) ->
//               RESP (response held until the host consumes it).
//               Optional macro WB_CMD_MASTER_TIMEOUT_EN adds a bus-cycle ack
//               timeout that completes the transfer with rsp_err_o=1.
// Revision    : 1.0 - initial release
// ============================================================================
module wishbone_cmd_master #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
    input  logic        clk,
    input  logic        rst,
    // host command channel
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    // host response channel
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    // Wishbone master port
    output logic        m_we_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    input  logic        m_int_i,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_dat;
    logic        r_m_we;
    logic        r_m_cyc;
    logic        r_m_stb;
    logic [31:0] r_m_adr;
    logic [31:0] r_m_dat;
    logic        r_irq;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    logic        r_rsp_err;
    logic [15:0] r_count;
    logic        w_timeout;

    // The count reaches TIMEOUT_CYCLES on the edge that would increment it
    // from TIMEOUT_CYCLES-1, i.e. after exactly TIMEOUT_CYCLES ack-less cycles.
    assign w_timeout = (r_count == (TIMEOUT_CYCLES - 16'd1));
    assign rsp_err_o = r_rsp_err;
`else
    logic        w_unused_cfg;

    // Without the timeout feature the depth parameter has no function.
    assign w_unused_cfg = ^TIMEOUT_CYCLES;
    assign rsp_err_o    = 1'b0;
`endif

    // Command/bus/response sequencer; every output is a register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= 32'd0;
            r_m_we      <= 1'b0;
            r_m_cyc     <= 1'b0;
            r_m_stb     <= 1'b0;
            r_m_adr     <= 32'd0;
            r_m_dat     <= 32'd0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
            r_count     <= 16'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid_i && r_cmd_ready) begin
                        r_state     <= ST_BUS;
                        r_cmd_ready <= 1'b0;
                        r_m_cyc     <= 1'b1;
                        r_m_stb     <= 1'b1;
                        r_m_we      <= cmd_we_i;
                        r_m_adr     <= cmd_adr_i;
                        // write data is only driven for writes
                        r_m_dat     <= cmd_we_i ? cmd_dat_i : 32'd0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                        r_count     <= 16'd0;
`endif
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_BUS: begin
                    if (m_ack_i) begin
                        // ack wins over a timeout landing on the same edge
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= r_m_we ? 32'd0 : m_dat_i;
                        r_m_cyc     <= 1'b0;
                        r_m_stb     <= 1'b0;
                        r_m_we      <= 1'b0;
                        r_m_adr     <= 32'd0;
                        r_m_dat     <= 32'd0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                    end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    else begin
                        r_count <= r_count + 16'd1;
                        if (w_timeout) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_dat   <= 32'd0;
                            r_rsp_err   <= 1'b1;
                            r_m_cyc     <= 1'b0;
                            r_m_stb     <= 1'b0;
                            r_m_we      <= 1'b0;
                            r_m_adr     <= 32'd0;
                            r_m_dat     <= 32'd0;
                        end
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Interrupt line is simply retimed, independent of the sequencer state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= m_int_i;
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign m_we_o      = r_m_we;
    assign m_cyc_o     = r_m_cyc;
    assign m_stb_o     = r_m_stb;
    assign m_adr_o     = r_m_adr;
    assign m_dat_o     = r_m_dat;
    assign irq_o       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_wishbone_cmd_master
// Description : Self-checking bench for wishbone_cmd_master. Expected
//               responses are queued when a command is issued and popped when
//               the DUT presents rsp_valid_o. Timeout scenarios are exercised
//               only when WB_CMD_MASTER_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wishbone_cmd_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [31:0] cmd_adr_i = 32'd0;
    logic [31:0] cmd_dat_i = 32'd0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        m_we_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i = 32'd0;
    logic        m_ack_i = 1'b0;
    logic        m_int_i = 1'b0;
    logic        irq_o;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    rsp_t exp_r;
    int   n_checks = 0;
    int   n_errors = 0;
    int   hs_count = 0;

    always #5 clk = ~clk;

    wishbone_cmd_master #(.TIMEOUT_CYCLES(16'd8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .m_we_o(m_we_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
        .m_ack_i(m_ack_i), .m_int_i(m_int_i), .irq_o(irq_o)
    );

    // Counts completed response handshakes outside reset.
    always @(posedge clk) begin
        if (rst && rsp_valid_o && rsp_ready_i) hs_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        m_int_i = 1'b1;
        #12;
        n_checks++;
        if ({cmd_ready_o, rsp_valid_o, rsp_err_o, m_we_o, m_cyc_o, m_stb_o, irq_o} !== 7'd0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b want 0000000", {cmd_ready_o, rsp_valid_o, rsp_err_o, m_we_o, m_cyc_o, m_stb_o, irq_o});
        end
        n_checks++;
        if ({rsp_dat_o, m_adr_o, m_dat_o} !== 96'd0) begin
            n_errors++;
            $display("FAIL reset_data: got %h %h %h want zeros", rsp_dat_o, m_adr_o, m_dat_o);
        end
        @(negedge clk);
        rst     = 1'b1;
        m_int_i = 1'b0;
        tick();
        n_checks++;
        if (cmd_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_ready: got %b want 1", cmd_ready_o);
        end
    endtask

    task automatic test_read();
        int hs0;
        sb.push_back(rsp_t'{32'h1234_5678, 1'b0});
        issue(1'b0, 32'h0000_0004, 32'hFFFF_FFFF);
        n_checks++;
        if ({cmd_ready_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o} !== {4'b0110, 32'h0000_0004, 32'd0}) begin
            n_errors++;
            $display("FAIL rd_bus: got rdy=%b cyc=%b stb=%b we=%b adr=%h dat=%h want 0 1 1 0 00000004 00000000",
                     cmd_ready_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o);
        end
        m_ack_i = 1'b1;
        m_dat_i = 32'h1234_5678;
        tick();
        m_ack_i = 1'b0;
        m_dat_i = 32'd0;
        n_checks++;
        if ({rsp_valid_o, m_cyc_o, m_stb_o} !== 3'b100) begin
            n_errors++;
            $display("FAIL rd_latency: got valid=%b cyc=%b stb=%b want 1 0 0", rsp_valid_o, m_cyc_o, m_stb_o);
        end
        exp_r = sb.pop_front();
        n_checks++;
        if ({rsp_dat_o, rsp_err_o} !== {exp_r.dat, exp_r.err}) begin
            n_errors++;
            $display("FAIL rd_data: got %h err=%b want %h err=%b", rsp_dat_o, rsp_err_o, exp_r.dat, exp_r.err);
        end
        hs0 = hs_count;
        tick();
        n_checks++;
        if ({rsp_valid_o, cmd_ready_o} !== 2'b01 || hs_count !== hs0 + 1) begin
            n_errors++;
            $display("FAIL rd_complete: got valid=%b ready=%b hs=%0d want 0 1 hs=%0d", rsp_valid_o, cmd_ready_o, hs_count, hs0 + 1);
        end
    endtask

    task automatic test_write();
        int hs0;
        bit seen;
        hs0 = hs_count;
        sb.push_back(rsp_t'{32'd0, 1'b0});
        issue(1'b1, 32'h0100_0010, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o} !== {3'b111, 32'h0100_0010, 32'hDEAD_BEEF}) begin
                n_errors++;
                $display("FAIL wr_hold[%0d]: got cyc=%b stb=%b we=%b adr=%h dat=%h want 1 1 1 01000010 deadbeef",
                         i, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o);
            end
            if (i < 3) tick();
        end
        m_ack_i = 1'b1;
        m_dat_i = 32'hCAFE_F00D;
        tick();
        m_ack_i = 1'b0;
        m_dat_i = 32'd0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL wr_rsp_timeout: got no rsp_valid_o want response");
        end else begin
            exp_r = sb.pop_front();
            n_checks++;
            if ({rsp_dat_o, rsp_err_o} !== {exp_r.dat, exp_r.err}) begin
                n_errors++;
                $display("FAIL wr_data: got %h err=%b want %h err=%b", rsp_dat_o, rsp_err_o, exp_r.dat, exp_r.err);
            end
        end
        tick();
        tick();
        n_checks++;
        if (hs_count !== hs0 + 1 || rsp_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL wr_single_rsp: got hs=%0d valid=%b want hs=%0d valid=0", hs_count, rsp_valid_o, hs0 + 1);
        end
    endtask

    task automatic test_backpressure();
        rsp_ready_i = 1'b0;
        sb.push_back(rsp_t'{32'hA5A5_0F0F, 1'b0});
        issue(1'b0, 32'h0000_0008, 32'd0);
        m_ack_i = 1'b1;
        m_dat_i = 32'hA5A5_0F0F;
        tick();
        m_ack_i = 1'b0;
        m_dat_i = 32'd0;
        exp_r = sb.pop_front();
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b1;
        cmd_adr_i   = 32'h0000_0020;
        cmd_dat_i   = 32'h0000_0055;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({rsp_valid_o, rsp_dat_o, rsp_err_o, cmd_ready_o, m_cyc_o} !== {1'b1, exp_r.dat, exp_r.err, 2'b00}) begin
                n_errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b dat=%h err=%b ready=%b cyc=%b want 1 %h %b 0 0",
                         i, rsp_valid_o, rsp_dat_o, rsp_err_o, cmd_ready_o, m_cyc_o, exp_r.dat, exp_r.err);
            end
            tick();
        end
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({rsp_valid_o, m_cyc_o, cmd_ready_o} !== 3'b001) begin
            n_errors++;
            $display("FAIL bp_release: got valid=%b cyc=%b ready=%b want 0 0 1", rsp_valid_o, m_cyc_o, cmd_ready_o);
        end
    endtask

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        m_dat_i = 32'h7777_7777;
        sb.push_back(rsp_t'{32'd0, 1'b1});
        issue(1'b0, 32'h0200_0000, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if (k < 8) begin
                if (m_cyc_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
                    n_errors++;
                    $display("FAIL to_wait[%0d]: got cyc=%b valid=%b want 1 0", k, m_cyc_o, rsp_valid_o);
                end
            end else begin
                exp_r = sb.pop_front();
                if ({m_cyc_o, m_stb_o, rsp_valid_o, rsp_dat_o, rsp_err_o} !== {3'b001, exp_r.dat, exp_r.err}) begin
                    n_errors++;
                    $display("FAIL to_expire: got cyc=%b stb=%b valid=%b dat=%h err=%b want 0 0 1 %h %b",
                             m_cyc_o, m_stb_o, rsp_valid_o, rsp_dat_o, rsp_err_o, exp_r.dat, exp_r.err);
                end
            end
        end
        tick();
        sb.push_back(rsp_t'{32'h7777_7777, 1'b0});
        issue(1'b0, 32'h0200_0004, 32'd0);
        for (int k = 1; k <= 7; k++) tick();
        m_ack_i = 1'b1;
        tick();
        m_ack_i = 1'b0;
        exp_r = sb.pop_front();
        n_checks++;
        if ({rsp_valid_o, rsp_dat_o, rsp_err_o} !== {1'b1, exp_r.dat, exp_r.err}) begin
            n_errors++;
            $display("FAIL to_ack_wins: got valid=%b dat=%h err=%b want 1 %h %b", rsp_valid_o, rsp_dat_o, rsp_err_o, exp_r.dat, exp_r.err);
        end
        m_dat_i = 32'd0;
        tick();
    endtask
`endif

    task automatic test_reset_mid_bus();
        int hs0;
        issue(1'b1, 32'h0300_0000, 32'h1111_2222);
        tick();
        n_checks++;
        if (m_cyc_o !== 1'b1) begin
            n_errors++;
            $display("FAIL rb_in_bus: got cyc=%b want 1", m_cyc_o);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({cmd_ready_o, rsp_valid_o, rsp_err_o, m_we_o, m_cyc_o, m_stb_o, irq_o, rsp_dat_o, m_adr_o, m_dat_o} !== 103'd0) begin
            n_errors++;
            $display("FAIL rb_async_clear: got ctrl=%b adr=%h dat=%h want all zero",
                     {cmd_ready_o, rsp_valid_o, rsp_err_o, m_we_o, m_cyc_o, m_stb_o, irq_o}, m_adr_o, m_dat_o);
        end
        hs0 = hs_count;
        m_ack_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b1;
        m_ack_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (rsp_valid_o !== 1'b0 || m_cyc_o !== 1'b0) begin
                n_errors++;
                $display("FAIL rb_no_rsp[%0d]: got valid=%b cyc=%b want 0 0", i, rsp_valid_o, m_cyc_o);
            end
        end
        n_checks++;
        if (cmd_ready_o !== 1'b1 || hs_count !== hs0) begin
            n_errors++;
            $display("FAIL rb_idle: got ready=%b hs=%0d want 1 hs=%0d", cmd_ready_o, hs_count, hs0);
        end
        sb.push_back(rsp_t'{32'hBEEF_0001, 1'b0});
        issue(1'b0, 32'h0300_0004, 32'd0);
        m_ack_i = 1'b1;
        m_dat_i = 32'hBEEF_0001;
        tick();
        m_ack_i = 1'b0;
        m_dat_i = 32'd0;
        exp_r = sb.pop_front();
        n_checks++;
        if ({rsp_valid_o, rsp_dat_o, rsp_err_o} !== {1'b1, exp_r.dat, exp_r.err}) begin
            n_errors++;
            $display("FAIL rb_next_cmd: got valid=%b dat=%h err=%b want 1 %h %b", rsp_valid_o, rsp_dat_o, rsp_err_o, exp_r.dat, exp_r.err);
        end
        tick();
    endtask

    task automatic test_irq_stray_ack();
        m_int_i = 1'b1;
        tick();
        m_int_i = 1'b0;
        n_checks++;
        if (irq_o !== 1'b1) begin
            n_errors++;
            $display("FAIL irq_rise: got %b want 1", irq_o);
        end
        tick();
        n_checks++;
        if (irq_o !== 1'b0) begin
            n_errors++;
            $display("FAIL irq_fall: got %b want 0", irq_o);
        end
        m_ack_i = 1'b1;
        m_dat_i = 32'h5555_AAAA;
        tick();
        m_ack_i = 1'b0;
        m_dat_i = 32'd0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({cmd_ready_o, rsp_valid_o, m_cyc_o, m_stb_o} !== 4'b1000) begin
                n_errors++;
                $display("FAIL stray_ack[%0d]: got ready=%b valid=%b cyc=%b stb=%b want 1 0 0 0",
                         i, cmd_ready_o, rsp_valid_o, m_cyc_o, m_stb_o);
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_backpressure();
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_bus();
        test_irq_stray_ack();
        n_checks++;
        if (sb.size() !== 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
